// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that runs one full_adder cell over WIDTH-bit operands, LSB first.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic c
);
  assign sum = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d, ps_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic fa_s, fa_c, run, load, last;
  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .sum(fa_s), .c(fa_c));
  assign run = state_q == RUN;
  assign load = !run && start;
  assign last = cnt_q == CW'(WIDTH - 1);
  // adder bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
  assign ps_next = (ps_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  always_comb begin
    state_d = load ? RUN : run ? (last ? DONE : RUN) : IDLE;
    a_d = load ? a : run ? a_q >> 1 : a_q;
    b_d = load ? b : run ? b_q >> 1 : b_q;
    ps_d = load ? '0 : run ? ps_next : ps_q;
    c_d = load ? cin : run ? fa_c : c_q;
    cnt_d = load ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    sum_d = (run && last) ? ps_next : sum_q;
    cout_d = (run && last) ? fa_c : cout_q;
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ps_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      ps_q <= ps_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and exhaustive checks of serial_add_ctrl at WIDTH=8 and WIDTH=3.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, start3 = 1'b0, cin3 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  logic busy8, done8, cout8, busy3, done3, cout3;
  logic [8:0] q8[$];
  logic [3:0] q3[$];
  int checks = 0, failures = 0, done_cnt8 = 0, cyc = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_add_ctrl #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .cin(cin3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("busy_done_exclusive", int'(busy8 & done8) + int'(busy3 & done3), 0);
    if (done8) begin
      done_cnt8++;
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else chk("result8", int'({cout8, sum8}), int'(q8.pop_front()));
    end
    if (done3) begin
      if (q3.size() == 0) chk("unexpected_done3", 1, 0);
      else chk("result3", int'({cout3, sum3}), int'(q3.pop_front()));
    end
  end

  // Called #1 after the start edge; counts later edges until done is seen.
  task automatic wait_done8(output int n, output int bc);
    n = 0;
    bc = int'(busy8);
    while (!done8 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      bc += int'(busy8);
    end
    if (!done8) chk("timeout8", 0, 1);
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic [8:0] exp);
    int n, bc;
    q8.push_back(exp);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8(n, bc);
    chk("latency8", n, 8);
    chk("busy_cycles8", bc, 8);
  endtask

  task automatic op3(input logic [2:0] ia, input logic [2:0] ib, input logic ic);
    int n;
    q3.push_back(4'({1'b0, ia}) + 4'({1'b0, ib}) + 4'(ic));
    a3 = ia; b3 = ib; cin3 = ic; start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    n = 0;
    while (!done3 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency3", n, 3);
  endtask

  initial begin
    int n, bc, t0, dc;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic vc [3];
    va = '{8'h01, 8'h80, 8'h7F};
    vb = '{8'h01, 8'h80, 8'h00};
    vc = '{1'b0, 1'b0, 1'b1};
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs8", int'({busy8, done8, cout8, sum8}), 0);
    chk("reset_outputs3", int'({busy3, done3, cout3, sum3}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    op8(8'h00, 8'h00, 1'b0, 9'h000);
    op8(8'hFF, 8'h01, 1'b0, 9'h100);
    op8(8'hA5, 8'h5A, 1'b1, 9'h100);
    repeat (2) @(posedge clk);
    #1;
    // second start and operand change while running must not disturb the result
    dc = done_cnt8;
    q8.push_back(9'h04B);
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 a8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8(n, bc);
    repeat (12) @(posedge clk);
    #1;
    chk("midop_done_count", done_cnt8 - dc, 1);
    chk("midop_idle", int'(busy8), 0);
    // start held high: one done every WIDTH+1 cycles
    for (int i = 0; i < 3; i++) q8.push_back(i == 0 ? 9'h002 : i == 1 ? 9'h100 : 9'h080);
    a8 = va[0]; b8 = vb[0]; cin8 = vc[0]; start8 = 1'b1;
    @(posedge clk);
    #1;
    t0 = -1;
    for (int i = 0; i < 3; i++) begin
      wait_done8(n, bc);
      if (t0 >= 0) chk("b2b_period", cyc - t0, 9);
      t0 = cyc;
      if (i < 2) begin
        a8 = va[i+1]; b8 = vb[i+1]; cin8 = vc[i+1];
        @(posedge clk);
        #1;
      end else start8 = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    // asynchronous reset mid-operation discards the run
    dc = done_cnt8;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", int'(busy8), 0);
    chk("async_reset_done", int'(done8), 0);
    chk("async_reset_sum", int'(sum8), 0);
    chk("async_reset_cout", int'(cout8), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt8 - dc, 0);
    op8(8'h10, 8'h20, 1'b0, 9'h030);
    for (int i = 0; i < 128; i++) op3(i[6:4], i[3:1], i[0]);
    repeat (4) @(posedge clk);
    #1;
    chk("queue8_drained", q8.size(), 0);
    chk("queue3_drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
